// File: rtl/step_batcher_if.sv
// step_batcher_if: commit/flush/halt inputs and batched step outputs of the step batcher
interface step_batcher_if #(
  parameter int CNT_WIDTH  = 4,
  parameter int STEP_WIDTH = 8
);
  logic                  commit_valid;
  logic [CNT_WIDTH-1:0]  commit_cnt;
  logic                  flush;
  logic                  simv_result;
  logic [STEP_WIDTH-1:0] step;
  logic                  flush_done;
  logic                  halted;
  logic                  overflow;
  logic [63:0]           total_steps;
  modport master (
    output commit_valid, commit_cnt, flush, simv_result,
    input  step, flush_done, halted, overflow, total_steps
  );
  modport slave (
    input  commit_valid, commit_cnt, flush, simv_result,
    output step, flush_done, halted, overflow, total_steps
  );
endinterface

// File: rtl/step_batcher.sv
// step_batcher: batches per-cycle commit counts into capped step pulses with timeout, drain and halt
module step_batcher #(
  parameter int STEP_WIDTH = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int BATCH      = 64,
  parameter int TIMEOUT    = 1000
) (
  input logic           clock,
  input logic           reset,
  step_batcher_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ACC_WIDTH-1:0] STEP_MAX = {{(ACC_WIDTH-STEP_WIDTH){1'b0}}, {STEP_WIDTH{1'b1}}};
  localparam logic [ACC_WIDTH-1:0] BATCH_V = ACC_WIDTH'(BATCH);
  typedef enum logic [1:0] {ACCUM, DRAIN, HALT} state_t;
  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [TW-1:0]        timer;
  logic [ACC_WIDTH:0]   in_w;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] e;
  logic                 want;
  logic                 fire;
  logic                 sat;
  // e never exceeds acc, so the subtraction cannot underflow; only the add can carry out
  always_comb begin
    in_w = bus.commit_valid ? (ACC_WIDTH+1)'(bus.commit_cnt) : '0;
    want = (state == DRAIN && acc != '0) ||
           (state == ACCUM && (acc >= BATCH_V || (acc != '0 && timer == TW'(TIMEOUT - 1))));
    fire = want && !bus.simv_result;
    e    = fire ? (acc > STEP_MAX ? STEP_MAX : acc) : '0;
    sum  = {1'b0, acc} - {1'b0, e} + in_w;
    sat  = sum[ACC_WIDTH];
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= ACCUM;
      acc             <= '0;
      timer           <= '0;
      bus.step        <= '0;
      bus.flush_done  <= 1'b0;
      bus.halted      <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.total_steps <= '0;
    end else begin
      acc             <= sat ? '1 : sum[ACC_WIDTH-1:0];
      bus.overflow    <= bus.overflow | sat;
      bus.step        <= e[STEP_WIDTH-1:0];
      bus.total_steps <= bus.total_steps + 64'(e);
      timer           <= (state != ACCUM || fire || acc == '0) ? '0 : timer + 1'b1;
      bus.flush_done  <= state == DRAIN && acc == '0 && !bus.simv_result;
      bus.halted      <= state == HALT || bus.simv_result;
      state           <= (state == HALT || bus.simv_result) ? HALT :
                         state == DRAIN ? (acc == '0 ? ACCUM : DRAIN) :
                         bus.flush ? DRAIN : ACCUM;
    end
  end
endmodule

// File: tb/tb_step_batcher.sv
// tb_step_batcher: scoreboard bench for step_batcher across default, large-batch and narrow-acc variants
module tb_step_batcher;
  logic clock;
  logic reset;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  typedef struct {int id; bit done; int val; int cyc;} ev_t;
  ev_t sbq[$];

  step_batcher_if #(.CNT_WIDTH(4), .STEP_WIDTH(8)) ia ();
  step_batcher_if #(.CNT_WIDTH(4), .STEP_WIDTH(8)) ib ();
  step_batcher_if #(.CNT_WIDTH(4), .STEP_WIDTH(4)) ic ();

  step_batcher u_a (.clock(clock), .reset(reset), .bus(ia));
  step_batcher #(.BATCH(1024)) u_b (.clock(clock), .reset(reset), .bus(ib));
  step_batcher #(.STEP_WIDTH(4), .ACC_WIDTH(8)) u_c (.clock(clock), .reset(reset), .bus(ic));

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input int id, input bit done, input int val, input int at);
    ev_t e;
    e.id = id; e.done = done; e.val = val; e.cyc = at;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ev(input int id, input bit done, input int val);
    ev_t e;
    compared++;
    if (sbq.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got id=%0d done=%0d val=%0d cyc=%0d expected none", id, done, val, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.id != id || e.done != done || e.val != val || e.cyc != cyc) begin
        mismatched++;
        $display("FAIL event: got id=%0d done=%0d val=%0d cyc=%0d expected id=%0d done=%0d val=%0d cyc=%0d",
                 id, done, val, cyc, e.id, e.done, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clock) begin
    int  sv[3];
    bit  dn[3];
    sv[0] = int'(ia.step); sv[1] = int'(ib.step); sv[2] = int'(ic.step);
    dn[0] = ia.flush_done; dn[1] = ib.flush_done; dn[2] = ic.flush_done;
    for (int i = 0; i < 3; i++) begin
      if (sv[i] != 0) check_ev(i, 1'b0, sv[i]);
      if (dn[i]) check_ev(i, 1'b1, 0);
    end
  end

  initial begin
    int s;
    reset = 1'b0;
    {ia.commit_valid, ia.commit_cnt, ia.flush, ia.simv_result} = '0;
    {ib.commit_valid, ib.commit_cnt, ib.flush, ib.simv_result} = '0;
    {ic.commit_valid, ic.commit_cnt, ic.flush, ic.simv_result} = '0;
    tick(3);
    chk("rst_step", 64'(ia.step), 0);
    chk("rst_flush_done", 64'(ia.flush_done), 0);
    chk("rst_halted", 64'(ia.halted), 0);
    chk("rst_overflow", 64'(ia.overflow), 0);
    chk("rst_total", ia.total_steps, 0);
    reset = 1'b1;
    tick(2);
    // single commit waits out the timeout
    ia.commit_valid = 1'b1; ia.commit_cnt = 4'd5;
    tick(1);
    ia.commit_valid = 1'b0;
    push(0, 1'b0, 5, cyc + 1000);
    tick(1010);
    chk("timeout_total", ia.total_steps, 5);
    // batch threshold
    s = cyc;
    push(0, 1'b0, 64, s + 9);
    ia.commit_valid = 1'b1; ia.commit_cnt = 4'd8;
    tick(8);
    ia.commit_valid = 1'b0;
    tick(5);
    chk("batch_total", ia.total_steps, 69);
    // flush with empty acc, held into DRAIN
    s = cyc;
    push(0, 1'b1, 0, s + 2);
    ia.flush = 1'b1;
    tick(2);
    ia.flush = 1'b0;
    tick(5);
    // flush coinciding with a batch emission
    s = cyc;
    push(0, 1'b0, 75, s + 6);
    push(0, 1'b1, 0, s + 7);
    ia.commit_valid = 1'b1; ia.commit_cnt = 4'd15;
    tick(5);
    ia.commit_valid = 1'b0; ia.flush = 1'b1;
    tick(1);
    ia.flush = 1'b0;
    tick(5);
    chk("flush_batch_total", ia.total_steps, 144);
    // cap and carry on the large-batch instance
    s = cyc;
    push(1, 1'b0, 255, s + 22);
    push(1, 1'b0, 45, s + 23);
    push(1, 1'b1, 0, s + 24);
    ib.commit_valid = 1'b1; ib.commit_cnt = 4'd15;
    tick(20);
    ib.commit_valid = 1'b0; ib.flush = 1'b1;
    tick(1);
    ib.flush = 1'b0;
    tick(6);
    chk("cap_total", ib.total_steps, 300);
    // halt suppresses a due emission and all later output
    ia.commit_valid = 1'b1; ia.commit_cnt = 4'd15;
    tick(5);
    ia.commit_valid = 1'b0; ia.simv_result = 1'b1;
    tick(1);
    ia.simv_result = 1'b0;
    tick(2);
    chk("halt_halted", 64'(ia.halted), 1);
    chk("halt_step", 64'(ia.step), 0);
    ia.flush = 1'b1; ia.commit_valid = 1'b1; ia.commit_cnt = 4'd3;
    tick(1);
    ia.flush = 1'b0; ia.commit_valid = 1'b0;
    tick(1100);
    chk("halt_sticky", 64'(ia.halted), 1);
    chk("halt_total", ia.total_steps, 144);
    // reset while draining a large acc
    ib.commit_valid = 1'b1; ib.commit_cnt = 4'd15;
    tick(34);
    ib.commit_valid = 1'b0; ib.flush = 1'b1;
    tick(1);
    ib.flush = 1'b0; reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("rdrain_step", 64'(ib.step), 0);
    chk("rdrain_total", ib.total_steps, 0);
    chk("rdrain_flush_done", 64'(ib.flush_done), 0);
    chk("rdrain_halt_cleared", 64'(ia.halted), 0);
    tick(1100);
    chk("rdrain_idle_total", ib.total_steps, 0);
    // saturation on the 8-bit accumulator while halted
    ic.simv_result = 1'b1;
    tick(1);
    ic.simv_result = 1'b0; ic.commit_valid = 1'b1; ic.commit_cnt = 4'd15;
    tick(17);
    chk("sat_edge_no_ovf", 64'(ic.overflow), 0);
    chk("sat_halted", 64'(ic.halted), 1);
    tick(1);
    chk("sat_ovf", 64'(ic.overflow), 1);
    ic.commit_valid = 1'b0;
    tick(5);
    chk("sat_ovf_sticky", 64'(ic.overflow), 1);
    chk("sat_step", 64'(ic.step), 0);
    tick(3);
    while (sbq.size() != 0) begin
      ev_t e;
      e = sbq.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_event: got none expected id=%0d done=%0d val=%0d cyc=%0d", e.id, e.done, e.val, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
